// File: rtl/boot_loader.sv
// boot_loader -- byte-stream boot sequencer for the instruction and data BRAMs.
//
// Consumes blocks {TGT, CNT_LO, CNT_HI, payload[4*CNT]} from a byte source,
// packs payload bytes little-endian into 32-bit words and writes them through
// the BRAM write ports. Each target keeps its own append pointer. TGT 0xFF
// releases the core (init_done high, pc_stall low); malformed streams latch a
// sticky error and keep the core stalled. Both end states hold until reset.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   rx_data/valid   incoming byte stream
//   rx_ready        byte accepted when rx_valid & rx_ready at a rising edge
//   mem_w_addr      word-aligned byte address of the current write
//   mem_w_dat       assembled word
//   mem_w_byte_enb  4'b1111 during a write
//   i_w_enb/d_w_enb instruction / data BRAM write strobes
//   init_done       high only in RUN (data-BRAM port mux select)
//   pc_stall        low only in RUN
//   error           sticky fault flag
//   words_loaded    words written since reset, saturating
//
// Optional feature: define BOOT_LOADER_CHECKSUM_EN to require one XOR checksum
// byte after each block's payload.
module boot_loader #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [31:0]           mem_w_dat,
  output logic [3:0]            mem_w_byte_enb,
  output logic                  i_w_enb,
  output logic                  d_w_enb,
  output logic                  init_done,
  output logic                  pc_stall,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_HDR_TGT, S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE, S_CHECK, S_RUN, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic                  tgt_q;          // 0 = instruction, 1 = data
  logic [7:0]            cnt_lo_q;
  logic [15:0]           rem_q;
  logic [1:0]            bidx_q;
  logic [31:0]           asm_q, asm_d;
  logic [16:0]           ptr_i_q, ptr_d_q;
  logic [15:0]           words_q;
  logic                  rx_ready_q, rx_ready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           dat_q, dat_d;
  logic                  i_w_q, i_w_d, d_w_q, d_w_d;
  logic                  init_q, init_d, stall_q, stall_d, err_q, err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic        accept;
  logic [15:0] cnt_full;
  logic [16:0] ptr_cur;
  logic        fits;

  // Acceptance uses the registered ready so the source sees exactly what we act on.
  assign accept   = rx_valid & rx_ready_q;
  assign cnt_full = {rx_data, cnt_lo_q};
  assign ptr_cur  = tgt_q ? ptr_d_q : ptr_i_q;
  // 17-bit sum cannot wrap: pointer <= DEPTH_WORDS, count <= 0xFFFF.
  assign fits     = (ptr_cur + {1'b0, cnt_full}) <= 17'(DEPTH_WORDS);

  // Little-endian packing: each new byte enters at the top, so after four
  // bytes the first one has reached bits [7:0].
  always_comb begin
    asm_d = asm_q;
    if (state_q == S_DATA && accept) asm_d = {rx_data, asm_q[31:8]};
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_HDR_TGT;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR_TGT: if (accept) begin
        if (rx_data == 8'h00 || rx_data == 8'h01) state_d = S_HDR_LO;
        else if (rx_data == 8'hFF)                state_d = S_RUN;
        else                                      state_d = S_ERROR;
      end
      S_HDR_LO: if (accept) state_d = S_HDR_HI;
      S_HDR_HI: if (accept) begin
        if (!fits)                state_d = S_ERROR;
`ifdef BOOT_LOADER_CHECKSUM_EN
        else if (cnt_full == '0)  state_d = S_CHECK;
`else
        else if (cnt_full == '0)  state_d = S_HDR_TGT;
`endif
        else                      state_d = S_DATA;
      end
      S_DATA: if (accept && bidx_q == 2'd3) state_d = S_WRITE;
      S_WRITE: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (rem_q == 16'd1) state_d = S_CHECK;
`else
        if (rem_q == 16'd1) state_d = S_HDR_TGT;
`endif
        else                state_d = S_DATA;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CHECK: if (accept) state_d = (rx_data == csum_q) ? S_HDR_TGT : S_ERROR;
`endif
      S_RUN:   state_d = S_RUN;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // Output logic: outputs are registered from the next state, so a write
  // strobe is visible for exactly the cycle the FSM spends in WRITE.
  always_comb begin
    rx_ready_d = (state_d == S_HDR_TGT) || (state_d == S_HDR_LO) ||
                 (state_d == S_HDR_HI)  || (state_d == S_DATA)   ||
                 (state_d == S_CHECK);
    i_w_d   = (state_d == S_WRITE) && !tgt_q;
    d_w_d   = (state_d == S_WRITE) &&  tgt_q;
    init_d  = (state_d == S_RUN);
    stall_d = (state_d != S_RUN);
    err_d   = (state_d == S_ERROR);
    addr_d  = addr_q;
    dat_d   = dat_q;
    if (state_d == S_WRITE) begin
      addr_d = {ptr_cur[ADDR_WIDTH-3:0], 2'b00};
      dat_d  = asm_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready_q <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      i_w_q      <= 1'b0;
      d_w_q      <= 1'b0;
      init_q     <= 1'b0;
      stall_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      i_w_q      <= i_w_d;
      d_w_q      <= d_w_d;
      init_q     <= init_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  // Block bookkeeping: target, remaining count, byte index, pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_q    <= 1'b0;
      cnt_lo_q <= '0;
      rem_q    <= '0;
      bidx_q   <= '0;
      asm_q    <= '0;
      ptr_i_q  <= '0;
      ptr_d_q  <= '0;
      words_q  <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_HDR_TGT: if (accept && rx_data[7:1] == 7'd0) tgt_q <= rx_data[0];
        S_HDR_LO:  if (accept) cnt_lo_q <= rx_data;
        S_HDR_HI:  if (accept) begin
          rem_q  <= cnt_full;
          bidx_q <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum_q <= '0;
`endif
        end
        S_DATA: if (accept) begin
          asm_q  <= asm_d;
          bidx_q <= bidx_q + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ rx_data;
`endif
        end
        S_WRITE: begin
          if (tgt_q) ptr_d_q <= ptr_d_q + 17'd1;
          else       ptr_i_q <= ptr_i_q + 17'd1;
          if (words_q != 16'hFFFF) words_q <= words_q + 16'd1;
          rem_q <= rem_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign rx_ready       = rx_ready_q;
  assign mem_w_addr     = addr_q;
  assign mem_w_dat      = dat_q;
  assign mem_w_byte_enb = {4{i_w_q | d_w_q}};
  assign i_w_enb        = i_w_q;
  assign d_w_enb        = d_w_q;
  assign init_done      = init_q;
  assign pc_stall       = stall_q;
  assign error          = err_q;
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: expected BRAM writes are queued as
// payload words are driven and matched against observed write strobes.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [11:0] mem_w_addr;
  logic [31:0] mem_w_dat;
  logic [3:0]  mem_w_byte_enb;
  logic        i_w_enb, d_w_enb, init_done, pc_stall, error;
  logic [15:0] words_loaded;

  boot_loader #(.ADDR_WIDTH(12), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_w_addr(mem_w_addr), .mem_w_dat(mem_w_dat),
    .mem_w_byte_enb(mem_w_byte_enb), .i_w_enb(i_w_enb), .d_w_enb(d_w_enb),
    .init_done(init_done), .pc_stall(pc_stall), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Scoreboard entry: {is_data, addr[11:0], data[31:0]}
  logic [44:0] sb_q[$];
  logic [44:0] mon_e;
  int          exp_ptr[2];
  int          exp_words;
  logic [7:0]  csum;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write monitor: every strobe cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (i_w_enb || d_w_enb) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {18'd0, d_w_enb, i_w_enb, mem_w_addr, mem_w_dat}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("write", {18'd0, d_w_enb, i_w_enb, mem_w_addr, mem_w_dat},
            {18'd0, mon_e[44], ~mon_e[44], mon_e[43:32], mon_e[31:0]});
        chk("byte_enb", 64'(mem_w_byte_enb), 64'hF);
      end
    end else if (mem_w_byte_enb != 4'h0) begin
      chk("byte_enb_idle", 64'(mem_w_byte_enb), 64'h0);
    end
  end

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] tgt, input logic [15:0] cnt);
    send(tgt);
    send(cnt[7:0]);
    send(cnt[15:8]);
    csum = '0;
  endtask

  task automatic send_word(input int tgt, input logic [31:0] w);
    sb_q.push_back({tgt[0], 12'(exp_ptr[tgt] * 4), w});
    exp_ptr[tgt]++;
    exp_words++;
    for (int i = 0; i < 4; i++) begin
      send(w[8*i +: 8]);
      csum = csum ^ w[8*i +: 8];
    end
    chk("write_latency", 64'(i_w_enb | d_w_enb), 64'd1);
  endtask

  task automatic end_block();
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(csum);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    chk({tag, "_addr"},     64'(mem_w_addr), 64'd0);
    chk({tag, "_dat"},      64'(mem_w_dat), 64'd0);
    chk({tag, "_benb"},     64'(mem_w_byte_enb), 64'd0);
    chk({tag, "_strobes"},  64'({i_w_enb, d_w_enb}), 64'd0);
    chk({tag, "_init"},     64'(init_done), 64'd0);
    chk({tag, "_stall"},    64'(pc_stall), 64'd1);
    chk({tag, "_error"},    64'(error), 64'd0);
    chk({tag, "_words"},    64'(words_loaded), 64'd0);
  endtask

  task automatic apply_reset(input string tag);
    rst      = 1'b0;
    rx_valid = 1'b0;
    #1;
    check_reset_vals(tag);
    chk({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
    exp_ptr   = '{0, 0};
    exp_words = 0;
    csum      = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_after_reset"}, 64'(rx_ready), 64'd1);
  endtask

  initial begin
    exp_ptr   = '{0, 0};
    exp_words = 0;
    csum      = '0;

    // Power-on reset
    @(negedge clk);
    apply_reset("por");

    // Instruction block, two words, then run
    send_hdr(8'h00, 16'd2);
    send_word(0, 32'h00500293);
    send_word(0, 32'h00100313);
    end_block();
    chk("instr_stall_before_run", 64'(pc_stall), 64'd1);
    send(8'hFF);
    chk("instr_words", 64'(words_loaded), 64'(exp_words));
    chk("instr_init_done", 64'(init_done), 64'd1);
    chk("instr_pc_stall", 64'(pc_stall), 64'd0);
    chk("run_rx_ready", 64'(rx_ready), 64'd0);
    chk("run_error", 64'(error), 64'd0);

    // Two data blocks appending to the same pointer
    apply_reset("rst_data");
    send_hdr(8'h01, 16'd2);
    send_word(1, 32'h00000001);
    send_word(1, 32'h00000002);
    end_block();
    send_hdr(8'h01, 16'd1);
    send_word(1, 32'h00000003);
    end_block();
    @(negedge clk);
    chk("data_words", 64'(words_loaded), 64'(exp_words));
    chk("data_init_before_run", 64'(init_done), 64'd0);
    send(8'hFF);
    chk("data_init_after_run", 64'(init_done), 64'd1);

    // Illegal target byte
    apply_reset("rst_badtgt");
    send(8'h02);
    chk("badtgt_error", 64'(error), 64'd1);
    chk("badtgt_rx_ready", 64'(rx_ready), 64'd0);
    chk("badtgt_stall", 64'(pc_stall), 64'd1);
    repeat (3) @(negedge clk);
    chk("badtgt_error_sticky", 64'(error), 64'd1);
    chk("badtgt_init", 64'(init_done), 64'd0);

    // Block larger than the BRAM
    apply_reset("rst_ovf");
    send_hdr(8'h00, 16'd1025);
    chk("cnt1025_error", 64'(error), 64'd1);

    // Exactly full, then one more word overflows
    apply_reset("rst_full");
    send_hdr(8'h00, 16'd1024);
    for (int i = 0; i < 1024; i++) send_word(0, 32'hA5000000 ^ 32'(i * 32'h00010203));
    end_block();
    @(negedge clk);
    chk("full_words", 64'(words_loaded), 64'd1024);
    chk("full_no_error", 64'(error), 64'd0);
    send_hdr(8'h00, 16'd1);
    chk("full_plus1_error", 64'(error), 64'd1);

    // Reset in the middle of a word, then a fresh block starts at address 0
    apply_reset("rst_mid_pre");
    send_hdr(8'h00, 16'd1);
    send(8'hAA);
    send(8'hBB);
    apply_reset("rst_mid");
    send_hdr(8'h00, 16'd1);
    send_word(0, 32'hCAFEF00D);
    end_block();
    @(negedge clk);
    chk("mid_words", 64'(words_loaded), 64'd1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Good checksum returns to header, bad checksum faults
    apply_reset("rst_csum");
    send_hdr(8'h00, 16'd1);
    send_word(0, 32'h44332211);
    send(8'h44);
    chk("csum_ok_ready", 64'(rx_ready), 64'd1);
    chk("csum_ok_error", 64'(error), 64'd0);
    send_hdr(8'h00, 16'd1);
    send_word(0, 32'h44332211);
    send(8'h45);
    chk("csum_bad_error", 64'(error), 64'd1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
